// File: rtl/param_counter_pkg.sv
// Shared encodings and helpers for the parametrised decade counter.
// Holds mode/direction encodings, digit maxima and the decimal digit clamp.
package param_counter_pkg;

    localparam logic MODE_DEC = 1'b0;
    localparam logic MODE_HEX = 1'b1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam logic [3:0] DEC_MAX = 4'd9;
    localparam logic [3:0] HEX_MAX = 4'd15;

    // In decimal mode any digit above 9 is read as 9.
    function automatic logic [3:0] digit_clamp(
        input logic [3:0] value,
        input logic       mode
    );
        if (mode == MODE_DEC && value > DEC_MAX) begin
            return DEC_MAX;
        end
        return value;
    endfunction

endpackage

// File: rtl/counter_digit.sv
// Combinational next-value logic for one counter digit.
// Ports: cur (digit), mode (dec/hex), dir (up/down), cin (step in)
//        -> next (digit value), cout (carry/borrow to next digit).
module counter_digit
    import param_counter_pkg::*;
(
    input  logic [3:0] cur,
    input  logic       mode,
    input  logic       dir,
    input  logic       cin,
    output logic [3:0] next,
    output logic       cout
);

    logic [3:0] cur_c;
    logic [3:0] dmax;

    always_comb begin
        cur_c = digit_clamp(cur, mode);
        dmax  = (mode == MODE_HEX) ? HEX_MAX : DEC_MAX;
        // An untouched digit keeps its raw value, even if out of range.
        next  = cur;
        cout  = 1'b0;
        if (cin) begin
            if (dir == DIR_UP) begin
                if (cur_c >= dmax) begin
                    next = 4'd0;
                    cout = 1'b1;
                end else begin
                    next = cur_c + 4'd1;
                end
            end else begin
                if (cur_c == 4'd0) begin
                    next = dmax;
                    cout = 1'b1;
                end else begin
                    next = cur_c - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/param_decade_counter.sv
// N-digit up/down counter with radix select, programmable limit,
// wrap/saturate policy, per-digit load and carry/zero/limit flags.
// Ports: clk, reset (sync, high), tick, enable, mode, updown, sat,
//        load, load_sel, load_value, limit -> count, carry, at_zero, at_limit.
module param_decade_counter
    import param_counter_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int SELW   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  enable,
    input  logic                  mode,
    input  logic                  updown,
    input  logic                  sat,
    input  logic                  load,
    input  logic [SELW-1:0]       load_sel,
    input  logic [3:0]            load_value,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic                  at_zero,
    output logic                  at_limit
);

    logic [4*DIGITS-1:0] count_q;
    logic [4*DIGITS-1:0] count_d;
    logic                carry_q;
    logic                carry_d;
    logic [4*DIGITS-1:0] eff_limit;
    logic [4*DIGITS-1:0] step_val;
    logic [DIGITS:0]     chain;

    assign chain[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign eff_limit[4*i +: 4] = digit_clamp(limit[4*i +: 4], mode);

        counter_digit u_digit (
            .cur  (count_q[4*i +: 4]),
            .mode (mode),
            .dir  (updown),
            .cin  (chain[i]),
            .next (step_val[4*i +: 4]),
            .cout (chain[i+1])
        );
    end

    assign at_zero  = (count_q == '0);
    // Packed vector compare is unsigned, most-significant digit first.
    assign at_limit = (count_q >= eff_limit);

    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (load) begin
            if (int'(load_sel) < DIGITS) begin
                count_d[int'(load_sel)*4 +: 4] = digit_clamp(load_value, mode);
            end
        end else if (tick && enable) begin
            if (updown == DIR_UP) begin
                if (at_limit) begin
                    if (!sat) begin
                        count_d = '0;
                        carry_d = 1'b1;
                    end
                end else begin
                    count_d = step_val;
                    carry_d = chain[DIGITS];
                end
            end else begin
                if (at_zero) begin
                    if (!sat) begin
                        count_d = eff_limit;
                        carry_d = 1'b1;
                    end
                end else begin
                    count_d = step_val;
                    carry_d = chain[DIGITS];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    assign count = count_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_param_decade_counter.sv
// Directed self-checking bench for param_decade_counter (DIGITS = 4).
// Inputs change after the falling edge; outputs are checked on it.
module tb_param_decade_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        enable;
    logic        mode;
    logic        updown;
    logic        sat;
    logic        load;
    logic [1:0]  load_sel;
    logic [3:0]  load_value;
    logic [15:0] limit;
    logic [15:0] count;
    logic        carry;
    logic        at_zero;
    logic        at_limit;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    param_decade_counter #(.DIGITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .enable     (enable),
        .mode       (mode),
        .updown     (updown),
        .sat        (sat),
        .load       (load),
        .load_sel   (load_sel),
        .load_value (load_value),
        .limit      (limit),
        .count      (count),
        .carry      (carry),
        .at_zero    (at_zero),
        .at_limit   (at_limit)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic load_count(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            load       = 1'b1;
            load_sel   = 2'(i);
            load_value = v[4*i +: 4];
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; enable = 1'b0; mode = 1'b0;
        updown = 1'b1; sat = 1'b0; load = 1'b0; load_sel = '0;
        load_value = '0; limit = 16'h9999;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_count", count, 16'h0000);
        chk("rst_carry", {15'd0, carry}, 16'd0);
        chk("rst_zero", {15'd0, at_zero}, 16'd1);
        chk("rst_lim", {15'd0, at_limit}, 16'd0);
        limit = 16'h0000;
        #1;
        chk("rst_lim0", {15'd0, at_limit}, 16'd1);
        limit = 16'h9999;
        @(negedge clk);

        // Wrap up at 9999
        enable = 1'b1;
        load_count(16'h9998);
        chk("wu_load", count, 16'h9998);
        do_tick();
        chk("wu_t1", count, 16'h9999);
        chk("wu_c1", {15'd0, carry}, 16'd0);
        chk("wu_lim", {15'd0, at_limit}, 16'd1);
        do_tick();
        chk("wu_t2", count, 16'h0000);
        chk("wu_c2", {15'd0, carry}, 16'd1);
        @(negedge clk);
        chk("wu_c3", {15'd0, carry}, 16'd0);

        // Down wrap to limit 0059
        limit  = 16'h0059;
        updown = 1'b0;
        do_tick();
        chk("dw_t1", count, 16'h0059);
        chk("dw_c1", {15'd0, carry}, 16'd1);
        do_tick();
        chk("dw_t2", count, 16'h0058);
        chk("dw_c2", {15'd0, carry}, 16'd0);

        // Borrow ripple across digits
        limit = 16'h9999;
        load_count(16'h0100);
        do_tick();
        chk("dw_brw", count, 16'h0099);

        // Saturate down at zero
        sat = 1'b1;
        load_count(16'h0000);
        do_tick();
        chk("sd_hold", count, 16'h0000);
        chk("sd_c", {15'd0, carry}, 16'd0);

        // Saturate up, hex
        mode   = 1'b1;
        updown = 1'b1;
        limit  = 16'h00FF;
        load_count(16'h00FE);
        do_tick();
        chk("su_t1", count, 16'h00FF);
        chk("su_c1", {15'd0, carry}, 16'd0);
        do_tick();
        chk("su_t2", count, 16'h00FF);
        chk("su_c2", {15'd0, carry}, 16'd0);
        do_tick();
        chk("su_t3", count, 16'h00FF);
        chk("su_c3", {15'd0, carry}, 16'd0);
        chk("su_lim", {15'd0, at_limit}, 16'd1);

        // Decimal limit clamp: 00AF reads as 0099
        mode  = 1'b0;
        sat   = 1'b0;
        limit = 16'h00AF;
        load_count(16'h0098);
        chk("lc_lo", {15'd0, at_limit}, 16'd0);
        do_tick();
        chk("lc_cnt", count, 16'h0099);
        chk("lc_hi", {15'd0, at_limit}, 16'd1);

        // Load clamp and priority over tick
        limit = 16'h9999;
        load_count(16'h1234);
        load = 1'b1; load_sel = 2'd2; load_value = 4'hC; tick = 1'b1;
        @(negedge clk);
        load = 1'b0; tick = 1'b0;
        chk("ld_clamp", count, 16'h1934);
        chk("ld_c", {15'd0, carry}, 16'd0);

        // enable low ignores ticks
        enable = 1'b0;
        do_tick();
        chk("en_off", count, 16'h1934);
        enable = 1'b1;

        // Mode switch: hex B read as 9 in decimal
        mode  = 1'b1;
        limit = 16'hFFFF;
        load_count(16'h003B);
        mode = 1'b0;
        do_tick();
        chk("ms_cnt", count, 16'h0040);

        // Reset mid-operation wins over tick and load
        load_count(16'h0512);
        do_tick();
        chk("rm_pre", count, 16'h0513);
        reset = 1'b1; tick = 1'b1; load = 1'b1;
        load_sel = 2'd0; load_value = 4'd7;
        @(negedge clk);
        reset = 1'b0; tick = 1'b0; load = 1'b0;
        chk("rm_cnt", count, 16'h0000);
        chk("rm_c", {15'd0, carry}, 16'd0);
        chk("rm_zero", {15'd0, at_zero}, 16'd1);
        do_tick();
        chk("rm_resume", count, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_decade_counter.md
Name: param_decade_counter

Overview:
- Parametrised N-digit up/down counter.
- Next generation of the four-digit multi_decade_counter.
- Runs on the single system clock, advanced by a one-cycle `tick` strobe instead of a divided clock.
- Adds decimal/hex radix select, programmable terminal limit, saturate-or-wrap policy, per-digit load and carry/status flags.
- Sits between the clock_divider (tick source) and the sseg_driver (consumes `count`).

Parameters:
- DIGITS, 4, number of 4-bit digits (1..8).
- SELW, $clog2(DIGITS) (min 1), width of the digit-select index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle count strobe from clock_divider.
- enable  in  1  counting enabled when 1.
- mode  in  1  0 = decimal (radix 10), 1 = hex (radix 16).
- updown  in  1  1 = count up, 0 = count down.
- sat  in  1  0 = wrap at the bounds, 1 = saturate at the bounds.
- load  in  1  load one digit this cycle.
- load_sel  in  SELW  index of the digit to load (0 = least significant).
- load_value  in  4  value to load.
- limit  in  4*DIGITS  terminal value, packed with digit 0 in bits [3:0].
- count  out  4*DIGITS  current count, packed with digit 0 in bits [3:0].
- carry  out  1  one-cycle pulse on wrap (up or down).
- at_zero  out  1  count == 0.
- at_limit  out  1  count >= effective limit.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
  - On reset: count = 0, carry = 0.
  - at_zero = 1 and at_limit = (effective limit == 0) the cycle after reset.
- Priority per edge: reset > load > step. A step occurs when tick & enable & ~load.
- Latency: count and carry update on the sampling edge and are visible the next cycle.
  - at_zero and at_limit are pure functions of the count register and limit; no extra latency.
- carry defaults to 0 every cycle. It is 1 only in the cycle after a wrapping step.
- Digit maximum:
  - decimal mode: 9; any digit value >= 9 counts as at max.
  - hex mode: 15.
- Effective limit: each limit digit is clamped to the digit maximum (decimal: 0xA..0xF read as 9).
  - Comparison is unsigned, most-significant digit first.
- Load: digit[load_sel] <= load_value, clamped to 9 in decimal mode.
  - Other digits are unchanged.
  - load_sel >= DIGITS: no change.
  - Load never produces carry.
- Up step:
  - If count >= effective limit: wrap policy sets count = 0 and carry = 1; saturate policy holds, carry = 0.
  - Otherwise, ripple increment in the same cycle: a digit at max becomes 0 and passes carry-in to the next digit.
- Down step:
  - If count == 0: wrap policy sets count = effective limit and carry = 1; saturate policy holds.
  - Otherwise, ripple decrement: a digit of 0 becomes its max and passes the borrow on.
  - Any decimal digit > 9 is first treated as 9.
- Mode switch mid-count:
  - No immediate change to count.
  - Hex digits above 9 are normalised only when that digit is next touched by a step.
- Changing limit below the current count: the next up step wraps (or holds under saturate). The next down step decrements normally.
- load and tick in the same cycle: load wins and the tick is dropped.
- reset together with load or tick: reset wins.
- enable = 0: ticks are ignored; load still works.

Decomposition:
- Package param_counter_pkg:
  - MODE_DEC / MODE_HEX encodings.
  - DEC_MAX = 4'd9, HEX_MAX = 4'd15.
  - DIR_UP / DIR_DOWN encodings.
  - Function digit_clamp(value, mode).
- One natural sub-module, counter_digit: combinational next-digit logic per digit.
  - Inputs: cur, mode, dir, cin.
  - Outputs: next, cout.
  - Instantiated DIGITS times in a generate chain.
- The top module holds the register, load mux, limit compare and flags.

Test Plan:
- Wrap up: DIGITS=4, decimal, limit=9999, count=9998, wrap, up, 2 ticks → 9999 then 0000; carry high exactly one cycle after the second tick.
- Down wrap to limit: decimal, limit=0059, count=0000, down, wrap, 1 tick → count=0059, carry=1 one cycle; next tick → 0058, carry=0.
- Saturate up: hex, limit=00FF, sat=1, count=00FE, 3 ticks → 00FF, 00FF, 00FF; at_limit=1; carry never asserted.
- Load clamp and priority: decimal, load_sel=2, load_value=0xC with tick same cycle, count=1234 → count=1934; no step applied.
- Mode switch: hex count=003B, switch to decimal, up tick → digit0 treated as 9, giving 0040.
- Reset mid-operation: counting up at 0512, reset with tick and load high → count=0000, carry=0, at_zero=1; counting resumes from 0000 next tick.
